// File: rtl/ahbl_to_apb.sv
// ahbl_to_apb: AHB-Lite subordinate to APB3 requester bridge, one transfer in flight.
// Optional ACCESS-phase timeout enabled by defining APB_TIMEOUT_EN.
module ahbl_to_apb #(
    parameter int W_HADDR        = 32,
    parameter int W_PADDR        = 20,
    parameter int W_DATA         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               ahbls_hready,
    output logic               ahbls_hready_resp,
    output logic               ahbls_hresp,
    input  logic [W_HADDR-1:0] ahbls_haddr,
    input  logic               ahbls_hwrite,
    input  logic [1:0]         ahbls_htrans,
    input  logic [2:0]         ahbls_hsize,
    input  logic [W_DATA-1:0]  ahbls_hwdata,
    output logic [W_DATA-1:0]  ahbls_hrdata,
    output logic [W_PADDR-1:0] apbm_paddr,
    output logic               apbm_psel,
    output logic               apbm_penable,
    output logic               apbm_pwrite,
    output logic [W_DATA-1:0]  apbm_pwdata,
    input  logic [W_DATA-1:0]  apbm_prdata,
    input  logic               apbm_pready,
    input  logic               apbm_pslverr
);
    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_WCAP   = 3'd1;
    localparam logic [2:0] S_SETUP  = 3'd2;
    localparam logic [2:0] S_ACCESS = 3'd3;
    localparam logic [2:0] S_ERR1   = 3'd4;
    localparam logic [2:0] S_ERR2   = 3'd5;
    localparam logic [2:0] S_RESP   = 3'd6;

    logic [2:0] state, state_nxt;
    logic       accept, can_accept, tmo;
    logic       unused;

    assign unused     = ^{ahbls_hsize, ahbls_htrans[0], ahbls_haddr[W_HADDR-1:W_PADDR]};
    assign can_accept = state == S_IDLE || state == S_RESP;
    assign accept     = can_accept && ahbls_hready && ahbls_htrans[1];

    always_comb begin
        state_nxt = S_IDLE;
        case (state)
            S_IDLE, S_RESP: state_nxt = accept ? (ahbls_hwrite ? S_WCAP : S_SETUP) : S_IDLE;
            S_WCAP:         state_nxt = S_SETUP;
            S_SETUP:        state_nxt = S_ACCESS;
            S_ACCESS:       state_nxt = apbm_pready ? (apbm_pslverr ? S_ERR1 : S_RESP)
                                                    : (tmo ? S_ERR1 : S_ACCESS);
            S_ERR1:         state_nxt = S_ERR2;
            default:        state_nxt = S_IDLE;
        endcase
    end

`ifdef APB_TIMEOUT_EN
    logic [15:0] tcnt;
    assign tmo = !apbm_pready && tcnt == 16'(TIMEOUT_CYCLES - 1);
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n)
            tcnt <= '0;
        else if (state == S_SETUP)
            tcnt <= '0;
        else if (state == S_ACCESS && !apbm_pready)
            tcnt <= tcnt + 16'd1;
`else
    assign tmo = 1'b0;
`endif

    // Outputs are registered from the next state so nothing passes combinationally bus-to-bus.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state             <= S_IDLE;
            apbm_psel         <= 1'b0;
            apbm_penable      <= 1'b0;
            apbm_pwrite       <= 1'b0;
            apbm_paddr        <= '0;
            apbm_pwdata       <= '0;
            ahbls_hrdata      <= '0;
            ahbls_hready_resp <= 1'b1;
            ahbls_hresp       <= 1'b0;
        end else begin
            state             <= state_nxt;
            apbm_psel         <= state_nxt == S_SETUP || state_nxt == S_ACCESS;
            apbm_penable      <= state_nxt == S_ACCESS;
            ahbls_hready_resp <= state_nxt == S_IDLE || state_nxt == S_RESP || state_nxt == S_ERR2;
            ahbls_hresp       <= state_nxt == S_ERR1 || state_nxt == S_ERR2;
            if (accept) begin
                apbm_paddr  <= ahbls_haddr[W_PADDR-1:0];
                apbm_pwrite <= ahbls_hwrite;
            end
            if (state == S_WCAP)
                apbm_pwdata <= ahbls_hwdata;
            if (state == S_ACCESS && apbm_pready && !apbm_pwrite)
                ahbls_hrdata <= apbm_prdata;
        end
    end
endmodule

// File: tb/tb_ahbl_to_apb.sv
// tb_ahbl_to_apb: directed checks of the AHB-Lite to APB3 bridge, both APB_TIMEOUT_EN builds.
module tb_ahbl_to_apb;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        hready, hready_resp, hresp, hwrite, psel, penable, pwrite, pready, pslverr;
    logic [1:0]  htrans;
    logic [2:0]  hsize;
    logic [31:0] haddr, hwdata, hrdata, pwdata, prdata;
    logic [19:0] paddr;
    int          errs = 0;
    int          checks = 0;

    assign hready = hready_resp;

    ahbl_to_apb #(.TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst_n(rst_n),
        .ahbls_hready(hready), .ahbls_hready_resp(hready_resp), .ahbls_hresp(hresp),
        .ahbls_haddr(haddr), .ahbls_hwrite(hwrite), .ahbls_htrans(htrans), .ahbls_hsize(hsize),
        .ahbls_hwdata(hwdata), .ahbls_hrdata(hrdata),
        .apbm_paddr(paddr), .apbm_psel(psel), .apbm_penable(penable), .apbm_pwrite(pwrite),
        .apbm_pwdata(pwdata), .apbm_prdata(prdata), .apbm_pready(pready), .apbm_pslverr(pslverr)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b1; haddr = '0; hwrite = 0; htrans = 2'b00; hsize = 3'd2; hwdata = '0;
        prdata = '0; pready = 1'b1; pslverr = 1'b0;
        #1 rst_n = 1'b0;
        tick; tick;
        chk("rst_hready", hready_resp, 1); chk("rst_hresp", hresp, 0);
        chk("rst_psel", psel, 0); chk("rst_penable", penable, 0); chk("rst_pwrite", pwrite, 0);
        chk("rst_paddr", paddr, 0); chk("rst_pwdata", pwdata, 0); chk("rst_hrdata", hrdata, 0);
        rst_n = 1'b1;
        tick;
        // BUSY transfer (htrans[1]=0) is a no-op
        htrans = 2'b01; haddr = 32'h4000_0044;
        tick;
        chk("noop_psel", psel, 0); chk("noop_hready", hready_resp, 1);
        // 1: zero-wait read
        htrans = 2'b10; haddr = 32'h4000_0008; hwrite = 0; prdata = 32'h1234_5678;
        tick; htrans = 2'b00;
        chk("rd_setup_psel", psel, 1); chk("rd_setup_pen", penable, 0);
        chk("rd_setup_paddr", paddr, 32'h8); chk("rd_setup_pwrite", pwrite, 0);
        chk("rd_setup_hready", hready_resp, 0);
        tick;
        chk("rd_acc_pen", penable, 1); chk("rd_acc_psel", psel, 1); chk("rd_acc_hready", hready_resp, 0);
        tick;
        chk("rd_resp_hready", hready_resp, 1); chk("rd_resp_hresp", hresp, 0);
        chk("rd_resp_hrdata", hrdata, 32'h1234_5678); chk("rd_resp_psel", psel, 0);
        tick;
        chk("rd_idle_hready", hready_resp, 1);
        // 2: write with two completer wait states
        pready = 0; htrans = 2'b10; haddr = 32'h4000_0004; hwrite = 1;
        tick; htrans = 2'b00; hwrite = 0; hwdata = 32'hA5A5_0003;
        chk("wr_wcap_hready", hready_resp, 0); chk("wr_wcap_psel", psel, 0);
        tick; hwdata = 32'hFFFF_FFFF;
        chk("wr_setup_psel", psel, 1); chk("wr_setup_pwrite", pwrite, 1);
        chk("wr_setup_pwdata", pwdata, 32'hA5A5_0003); chk("wr_setup_paddr", paddr, 32'h4);
        tick;
        chk("wr_acc1_pen", penable, 1); chk("wr_acc1_pwdata", pwdata, 32'hA5A5_0003);
        tick;
        chk("wr_acc2_pen", penable, 1); chk("wr_acc2_hready", hready_resp, 0);
        tick; pready = 1;
        chk("wr_acc3_pen", penable, 1); chk("wr_acc3_pwdata", pwdata, 32'hA5A5_0003);
        chk("wr_acc3_pwrite", pwrite, 1);
        tick;
        chk("wr_resp_hready", hready_resp, 1); chk("wr_resp_hresp", hresp, 0);
        chk("wr_resp_psel", psel, 0); chk("wr_resp_hrdata", hrdata, 32'h1234_5678);
        tick;
        // 3: read with pslverr
        pslverr = 1; prdata = 32'hDEAD_BEEF; htrans = 2'b10; haddr = 32'h4000_0010;
        tick; htrans = 2'b00;
        tick;
        tick; pslverr = 0;
        chk("err1_hready", hready_resp, 0); chk("err1_hresp", hresp, 1); chk("err1_psel", psel, 0);
        htrans = 2'b10; haddr = 32'h4000_0014;
        tick;
        chk("err2_hready", hready_resp, 1); chk("err2_hresp", hresp, 1);
        tick; htrans = 2'b00;
        chk("err_idle_hresp", hresp, 0); chk("err_idle_psel", psel, 0); chk("err_idle_hready", hready_resp, 1);
        tick;
        // 4: back-to-back write then read issued during RESP
        htrans = 2'b10; haddr = 32'h4000_0020; hwrite = 1;
        tick; htrans = 2'b00; hwrite = 0; hwdata = 32'h0000_00C3;
        tick;
        chk("b2b_wr_pwdata", pwdata, 32'hC3);
        tick; htrans = 2'b10; haddr = 32'h4000_0024; hwrite = 0; prdata = 32'h0BAD_F00D;
        chk("b2b_wr_acc_hready", hready_resp, 0);
        tick;
        chk("b2b_resp_hready", hready_resp, 1); chk("b2b_resp_psel", psel, 0);
        tick; htrans = 2'b00;
        chk("b2b_rd_setup_psel", psel, 1); chk("b2b_rd_setup_pen", penable, 0);
        chk("b2b_rd_paddr", paddr, 32'h24); chk("b2b_rd_pwrite", pwrite, 0);
        tick;
        tick;
        chk("b2b_rd_hrdata", hrdata, 32'h0BAD_F00D); chk("b2b_rd_hready", hready_resp, 1);
        tick;
        // 5: completer never ready
        pready = 0; htrans = 2'b10; haddr = 32'h4000_0030;
        tick; htrans = 2'b00;
        tick;
`ifdef APB_TIMEOUT_EN
        tick; tick; tick;
        chk("to_acc4_psel", psel, 1); chk("to_acc4_pen", penable, 1);
        tick;
        chk("to_err1_psel", psel, 0); chk("to_err1_pen", penable, 0);
        chk("to_err1_hresp", hresp, 1); chk("to_err1_hready", hready_resp, 0);
        tick; pready = 1; prdata = 32'h7777_7777;
        chk("to_err2_hready", hready_resp, 1); chk("to_err2_hresp", hresp, 1);
        tick;
        chk("to_late_psel", psel, 0); chk("to_late_hresp", hresp, 0);
        chk("to_late_hrdata", hrdata, 32'h0BAD_F00D);
        tick;
        chk("to_late_idle_psel", psel, 0);
`else
        for (int i = 0; i < 100; i++) tick;
        chk("hang_hready", hready_resp, 0); chk("hang_psel", psel, 1); chk("hang_pen", penable, 1);
        pready = 1; prdata = 32'h7777_7777;
        tick;
        chk("hang_resp_hready", hready_resp, 1); chk("hang_resp_hrdata", hrdata, 32'h7777_7777);
        tick;
`endif
        // 6: asynchronous reset during ACCESS
        pready = 0; htrans = 2'b10; haddr = 32'h4000_0038;
        tick; htrans = 2'b00;
        tick;
        chk("ar_acc_pen", penable, 1);
        #2 rst_n = 1'b0;
        #1;
        chk("ar_psel", psel, 0); chk("ar_pen", penable, 0); chk("ar_hready", hready_resp, 1);
        tick; rst_n = 1'b1;
        pready = 1; prdata = 32'h600D_CAFE; htrans = 2'b10; haddr = 32'h4000_000C;
        tick; htrans = 2'b00;
        chk("ar_rd_paddr", paddr, 32'hC);
        tick;
        tick;
        chk("ar_rd_hrdata", hrdata, 32'h600D_CAFE); chk("ar_rd_hready", hready_resp, 1);
        chk("ar_rd_hresp", hresp, 0);
        tick;
        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end
endmodule
